// File: rtl/arb_pkg.sv
// Shared types for the priority / round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/prio_rr_arbiter_prio_search.sv
// Combinational highest-index search, preferring the masked request set when it is non-empty.
module prio_search #(
  parameter int unsigned N = 2
) (
  input  logic [(2**N)-1:0] req,
  input  logic [(2**N)-1:0] mask,
  output logic              found,
  output logic [N-1:0]      idx
);

  localparam int unsigned M = 2 ** N;

  logic [M-1:0] masked;
  logic [M-1:0] pool;

  assign masked = req & mask;
  assign pool   = (|masked) ? masked : req;
  assign found  = |req;

  // Ascending scan: the last set bit seen is the highest index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < M; i++) begin
      if (pool[i]) idx = N'(i);
    end
  end

endmodule

// File: rtl/prio_rr_arbiter.sv
// Arbiter for one shared resource: fixed-priority or round-robin winner selection,
// grant held until done, requester withdrawal, or watchdog expiry.
module prio_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 2,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              rr_en,
  input  logic [(2**N)-1:0] req,
  input  logic              done,
  output logic [(2**N)-1:0] grant,
  output logic [N-1:0]      grant_id,
  output logic              grant_valid,
  output logic              timeout
);

  localparam int unsigned M      = 2 ** N;
  localparam int unsigned CW_RAW = $clog2(MAX_HOLD + 1);
  localparam int unsigned CW     = (CW_RAW == 0) ? 1 : CW_RAW;
  localparam bit          WD_EN  = (MAX_HOLD != 0);
  localparam logic [CW-1:0] LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_t   state_q, state_d;
  logic [M-1:0] grant_d;
  logic [N-1:0] id_d;
  logic         valid_d;
  logic         timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] ptr_q, ptr_d;

  logic [M-1:0] mask;
  logic         found;
  logic [N-1:0] win_idx;
  logic         expire;
  logic         release_now;

  // Round-robin favours indices below the last winner; fixed priority searches all.
  always_comb begin
    mask = '0;
    if (rr_en) begin
      for (int i = 0; i < M; i++) begin
        if (N'(i) < ptr_q) mask[i] = 1'b1;
      end
    end
  end

  prio_search #(.N(N)) u_search (
    .req  (req),
    .mask (mask),
    .found(found),
    .idx  (win_idx)
  );

  assign expire      = WD_EN && (cnt_q == LAST);
  assign release_now = done || !req[grant_id] || expire;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant;
    id_d      = grant_id;
    valid_d   = grant_valid;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        id_d    = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
        if (found) begin
          state_d = BUSY;
          grant_d = M'(1) << win_idx;
          id_d    = win_idx;
          valid_d = 1'b1;
          ptr_d   = win_idx;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d   = IDLE;
          grant_d   = '0;
          id_d      = '0;
          valid_d   = 1'b0;
          cnt_d     = '0;
          // Done and withdrawal both outrank a coincident watchdog expiry.
          timeout_d = expire && !done && req[grant_id];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      grant_id    <= id_d;
      grant_valid <= valid_d;
      timeout     <= timeout_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  grant_matches_id: assert property (@(posedge clk) disable iff (!clr_n)
    grant == (M'(grant_valid) << grant_id));

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed scoreboard bench for prio_rr_arbiter (N=2, MAX_HOLD=8).
module tb_prio_rr_arbiter;

  localparam int unsigned N        = 2;
  localparam int unsigned M        = 4;
  localparam int unsigned MAX_HOLD = 8;

  typedef struct packed {
    logic [15:0]  num;
    logic [N-1:0] id;
    logic         valid;
    logic         timeout;
  } exp_t;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         rr_en;
  logic [M-1:0] req;
  logic         done;
  logic [M-1:0] grant;
  logic [N-1:0] grant_id;
  logic         grant_valid;
  logic         timeout;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   vec_no      = 0;

  prio_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .rr_en      (rr_en),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t e);
    logic [M-1:0] eg;
    eg = e.valid ? (M'(1) << e.id) : '0;
    vectors++;
    if (grant !== eg || grant_id !== e.id || grant_valid !== e.valid || timeout !== e.timeout) begin
      miscompares++;
      $display("FAIL %s: got grant=%b id=%0d valid=%b timeout=%b, exp grant=%b id=%0d valid=%b timeout=%b",
               name, grant, grant_id, grant_valid, timeout, eg, e.id, e.valid, e.timeout);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic [M-1:0] r, input logic rr, input logic d,
                      input logic v, input logic [N-1:0] id, input logic t);
    @(posedge clk);
    #2;
    req   = r;
    rr_en = rr;
    done  = d;
    vec_no++;
    exp_q.push_back(exp_t'{num: 16'(vec_no), id: id, valid: v, timeout: t});
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d", e.num), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t z;
    z     = '0;
    clr_n = 1'b0;
    req   = '0;
    rr_en = 1'b0;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", z);
    @(negedge clk);
    clr_n = 1'b1;

    // 1: fixed priority, done with withdrawal, then index 0 wins
    step(4'b0101, 0, 0, 1, 2, 0);
    step(4'b0001, 0, 1, 0, 0, 0);
    step(4'b0001, 0, 0, 1, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0);

    // 2: round-robin rotation 3,2,1,0,3 with bubbles
    step(4'b1111, 1, 0, 1, 3, 0);
    step(4'b1111, 1, 1, 0, 0, 0);
    step(4'b1111, 1, 0, 1, 2, 0);
    step(4'b1111, 1, 1, 0, 0, 0);
    step(4'b1111, 1, 0, 1, 1, 0);
    step(4'b1111, 1, 1, 0, 0, 0);
    step(4'b1111, 1, 0, 1, 0, 0);
    step(4'b1111, 1, 1, 0, 0, 0);
    step(4'b1111, 1, 0, 1, 3, 0);
    step(4'b1111, 1, 1, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0);

    // 3: watchdog forced release, regrant, and a second full hold
    for (int i = 0; i < 8; i++) step(4'b0010, 0, 0, 1, 1, 0);
    step(4'b0010, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(4'b0010, 0, 0, 1, 1, 0);
    step(4'b0010, 0, 0, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 0, 0);

    // 4: other requests ignored while busy, then withdrawal aborts
    step(4'b0100, 0, 0, 1, 2, 0);
    step(4'b1100, 0, 0, 1, 2, 0);
    step(4'b0100, 0, 0, 1, 2, 0);
    step(4'b0000, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0);

    // 5: done coincides with watchdog expiry
    for (int i = 0; i < 8; i++) step(4'b1000, 0, 0, 1, 3, 0);
    step(4'b1000, 0, 1, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0);

    // Round-robin with sparse requests (last winner 3)
    step(4'b1010, 1, 0, 1, 1, 0);
    step(4'b1010, 1, 1, 0, 0, 0);
    step(4'b1010, 1, 0, 1, 3, 0);
    step(4'b1010, 1, 1, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0);

    // 6: asynchronous clear while busy
    step(4'b0100, 0, 0, 1, 2, 0);
    step(4'b0100, 0, 0, 1, 2, 0);
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #1;
    check("async_clear", z);
    @(posedge clk);
    #2;
    clr_n = 1'b1;
    step(4'b0000, 0, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0);
    // Pointer must restart at 0 after clear: round-robin picks 3, not 0.
    step(4'b1001, 1, 0, 1, 3, 0);
    step(4'b1001, 1, 1, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #4;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
